// File: rtl/shift_subtract_divider.sv
// Sequential restoring divider: DW-bit dividend by VW-bit divisor, one quotient
// bit per clock MSB first, with a single-cycle divide-by-zero path.
module shift_subtract_divider #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          S,
    input  logic [DW-1:0] c,
    input  logic [VW-1:0] a,
    output logic [DW-1:0] q,
    output logic [VW-1:0] r,
    output logic          busy,
    output logic          done,
    output logic          div_by_zero
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {IDLE, RUN, ZERO} state_t;

    state_t         state_reg, state_next;
    logic           s_d_reg;
    logic [CW-1:0]  count_reg;
    logic [DW-1:0]  dividend_reg;
    logic [VW-1:0]  divisor_reg;
    logic [VW-1:0]  p_reg;

    logic           launch;
    logic           last_step;
    logic [VW:0]    t;
    logic           ge;
    logic [VW-1:0]  p_next;

    assign launch    = S & ~s_d_reg;
    assign last_step = (count_reg == CW'(DW - 1));

    // A restoring step never leaves more than VW bits, so P is kept VW wide
    // and only the trial value T carries the extra bit.
    always_comb begin
        t      = {p_reg, dividend_reg[DW-1]};
        ge     = (t >= {1'b0, divisor_reg});
        p_next = ge ? VW'(t - {1'b0, divisor_reg}) : t[VW-1:0];
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (launch) state_next = (a == '0) ? ZERO : RUN;
            RUN:     if (last_step) state_next = IDLE;
            ZERO:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Quotient bits are shifted into the dividend register's vacated LSBs,
    // so after DW steps it holds the full quotient.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_d_reg      <= 1'b0;
            count_reg    <= '0;
            dividend_reg <= '0;
            divisor_reg  <= '0;
            p_reg        <= '0;
            q            <= '0;
            r            <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            div_by_zero  <= 1'b0;
        end else begin
            s_d_reg <= S;
            done    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (launch) begin
                        dividend_reg <= c;
                        divisor_reg  <= a;
                        p_reg        <= '0;
                        count_reg    <= '0;
                        busy         <= 1'b1;
                    end
                end
                RUN: begin
                    p_reg        <= p_next;
                    dividend_reg <= {dividend_reg[DW-2:0], ge};
                    count_reg    <= count_reg + 1'b1;
                    if (last_step) begin
                        q           <= {dividend_reg[DW-2:0], ge};
                        r           <= p_next;
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                ZERO: begin
                    q           <= '1;
                    r           <= VW'(dividend_reg);
                    div_by_zero <= 1'b1;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
